// File: rtl/tlul_pkg.sv
// TL-UL channel types used by the bridge host port (single-word, 32-bit data).
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic       a_valid;
    tl_a_op_e   a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [31:0] a_address;
    logic [3:0] a_mask;
    logic [31:0] a_data;
    tl_a_user_t a_user;
    logic       d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic       d_valid;
    tl_d_op_e   d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic       d_sink;
    logic [31:0] d_data;
    tl_d_user_t d_user;
    logic       d_error;
    logic       a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/uart_bridge_pkg.sv
// Command/response byte codes and FSM states for the UART-to-TL-UL bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CmdWrite   = 8'h57;
  localparam logic [7:0] CmdRead    = 8'h52;
  localparam logic [7:0] RspOk      = 8'h4B;
  localparam logic [7:0] RspErr     = 8'h45;
  localparam logic [7:0] RspUnknown = 8'h3F;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, REQ, WAIT_D, TX_STAT, TX_DATA
  } state_e;

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// A-channel integrity generator: folds command and data fields into 7-bit check codes.
module tlul_cmd_intg_gen
  import tlul_pkg::*;
(
  input  tl_h2d_t tl_i,
  output tl_h2d_t tl_o
);

  logic [41:0] cmd;
  logic [34:0] data;

  always_comb begin
    cmd  = {3'b000, tl_i.a_opcode, tl_i.a_address, tl_i.a_mask};
    data = {3'b000, tl_i.a_data};
    tl_o = tl_i;
    tl_o.a_user.cmd_intg  = cmd[6:0] ^ cmd[13:7] ^ cmd[20:14] ^ cmd[27:21] ^
                            cmd[34:28] ^ cmd[41:35];
    tl_o.a_user.data_intg = data[6:0] ^ data[13:7] ^ data[20:14] ^ data[27:21] ^
                            data[34:28];
  end

endmodule

// File: rtl/uart_bridge_tl_req.sv
// TL-UL request/response handshakes for the bridge: drives the A channel, accepts D.
module uart_bridge_tl_req
  import tlul_pkg::*;
#(
  parameter logic [7:0] SourceId = 8'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wait_d,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output tl_h2d_t     tl_h,
  input  tl_d2h_t     tl_d,
  output logic        a_done,
  output logic        d_done,
  output logic        d_error,
  output logic [31:0] rdata
);

  tl_h2d_t tl_raw;

  always_comb begin
    tl_raw           = '0;
    tl_raw.a_valid   = req;
    tl_raw.a_opcode  = write ? PutFullData : Get;
    tl_raw.a_size    = 2'd2;
    tl_raw.a_source  = SourceId;
    tl_raw.a_address = {addr[31:2], 2'b00};
    tl_raw.a_mask    = '1;
    tl_raw.a_data    = write ? wdata : '0;
    tl_raw.d_ready   = wait_d;
  end

  tlul_cmd_intg_gen u_intg_gen (
    .tl_i(tl_raw),
    .tl_o(tl_h)
  );

  assign a_done  = req && tl_d.a_ready;
  // d_ready only exists in WAIT_D, so a D beat coincident with the A handshake is ignored
  assign d_done  = wait_d && tl_d.d_valid;
  assign d_error = tl_d.d_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (d_done) begin
      rdata <= tl_d.d_data;
    end
  end

  // Source, opcode and integrity of the response are deliberately not inspected
  logic unused_d;
  assign unused_d = ^{tl_d, addr[1:0]};

endmodule

// File: rtl/uart_tlul_bridge.sv
// Byte-stream command parser driving single-word TL-UL transactions.
// Optional inter-byte timeout enabled with `define UART_BRIDGE_TIMEOUT_EN.
module uart_tlul_bridge
  import tlul_pkg::*;
  import uart_bridge_pkg::*;
#(
  parameter int unsigned ClockFrequency = 125_000_000,
  parameter int unsigned TimeoutUs      = 1000,
  parameter logic [7:0]  SourceId       = 8'h0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  output tl_h2d_t    tl_h_o,
  input  tl_d2h_t    tl_h_i,
  output logic       busy_o,
  output logic       overrun_o
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]  rsp_q, rsp_d;
  logic        overrun_q;
  logic        a_done, d_done, d_error;
  logic [31:0] rdata;
  logic        timeout;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = ClockFrequency / 1_000_000 * TimeoutUs;
  localparam int unsigned TimeoutWidth  = $clog2(TimeoutCycles + 1);

  logic [TimeoutWidth-1:0] tmo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (rx_valid_i || !(state_q inside {ADDR, DATA})) begin
      tmo_q <= '0;
    end else if (!timeout) begin
      tmo_q <= tmo_q + TimeoutWidth'(1);
    end
  end

  assign timeout = (state_q inside {ADDR, DATA}) && (tmo_q == TimeoutWidth'(TimeoutCycles));
`else
  logic [63:0] unused_cfg;
  assign unused_cfg = {ClockFrequency, TimeoutUs};
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_d      = rsp_q;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    case (state_q)
      IDLE: if (rx_valid_i) begin
        cnt_d = '0;
        if (rx_data_i == CmdWrite || rx_data_i == CmdRead) begin
          write_d = (rx_data_i == CmdWrite);
          state_d = ADDR;
        end else begin
          rsp_d   = RspUnknown;
          state_d = TX_STAT;
        end
      end
      // Bytes shift in from the top so the first (LSB) byte lands in [7:0]
      ADDR: if (rx_valid_i) begin
        addr_d = {rx_data_i, addr_q[31:8]};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = write_q ? DATA : REQ;
      end else if (timeout) begin
        state_d = IDLE;
      end
      DATA: if (rx_valid_i) begin
        wdata_d = {rx_data_i, wdata_q[31:8]};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = REQ;
      end else if (timeout) begin
        state_d = IDLE;
      end
      REQ: if (a_done) state_d = WAIT_D;
      WAIT_D: if (d_done) begin
        rsp_d   = d_error ? RspErr : RspOk;
        state_d = TX_STAT;
      end
      TX_STAT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rsp_q;
        if (tx_ready_i) begin
          cnt_d   = '0;
          state_d = (!write_q && rsp_q == RspOk) ? TX_DATA : IDLE;
        end
      end
      TX_DATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rdata[{cnt_q, 3'b000} +: 8];
        if (tx_ready_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      if (rx_valid_i && (state_q inside {REQ, WAIT_D, TX_STAT, TX_DATA})) overrun_q <= 1'b1;
    end
  end

  uart_bridge_tl_req #(
    .SourceId(SourceId)
  ) u_tl_req (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .req    (state_q == REQ),
    .wait_d (state_q == WAIT_D),
    .write  (write_q),
    .addr   (addr_q),
    .wdata  (wdata_q),
    .tl_h   (tl_h_o),
    .tl_d   (tl_h_i),
    .a_done (a_done),
    .d_done (d_done),
    .d_error(d_error),
    .rdata  (rdata)
  );

  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_tlul_bridge.sv
// Directed bench for uart_tlul_bridge; timeout checks change with UART_BRIDGE_TIMEOUT_EN.
module tb_uart_tlul_bridge;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  tl_h2d_t     tl_h;
  tl_d2h_t     tl_d;
  logic        a_ready = 1'b1;
  logic        d_valid = 1'b0;
  logic        d_error = 1'b0;
  logic [31:0] d_data = 32'h0;
  logic        busy, overrun;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    tl_d          = '0;
    tl_d.a_ready  = a_ready;
    tl_d.d_valid  = d_valid;
    tl_d.d_opcode = AccessAckData;
    tl_d.d_data   = d_data;
    tl_d.d_error  = d_error;
  end

  uart_tlul_bridge #(
    .ClockFrequency(125_000_000),
    .TimeoutUs     (1),
    .SourceId      (8'h0)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_valid_i(rx_valid),
    .rx_data_i (rx_data),
    .tx_valid_o(tx_valid),
    .tx_data_o (tx_data),
    .tx_ready_i(tx_ready),
    .tl_h_o    (tl_h),
    .tl_h_i    (tl_d),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic d_respond(input logic [31:0] data, input logic err);
    d_valid = 1'b1;
    d_data  = data;
    d_error = err;
    @(negedge clk);
    d_valid = 1'b0;
    d_error = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (tl_h.a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b want 0", tl_h.a_valid); end
    checks++; if (tl_h.d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready got %b want 0", tl_h.d_ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] cmd [9] = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 9; i++) send_byte(cmd[i]);
    checks++; if (tl_h.a_valid !== 1'b1) begin errors++; $display("FAIL wr_a_valid got %b want 1", tl_h.a_valid); end
    checks++; if (tl_h.a_opcode !== PutFullData) begin errors++; $display("FAIL wr_opcode got %h want 0", tl_h.a_opcode); end
    checks++; if (tl_h.a_address !== 32'h0001_0000) begin errors++; $display("FAIL wr_addr got %h want 00010000", tl_h.a_address); end
    checks++; if (tl_h.a_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data got %h want deadbeef", tl_h.a_data); end
    checks++; if (tl_h.a_mask !== 4'hF || tl_h.a_size !== 2'd2 || tl_h.a_source !== 8'h00) begin
      errors++; $display("FAIL wr_fields got mask %h size %0d src %h want f 2 00", tl_h.a_mask, tl_h.a_size, tl_h.a_source);
    end
    checks++; if (tl_h.d_ready !== 1'b0) begin errors++; $display("FAIL wr_d_ready_early got %b want 0", tl_h.d_ready); end
    @(negedge clk);
    checks++; if (tl_h.d_ready !== 1'b1 || tl_h.a_valid !== 1'b0) begin
      errors++; $display("FAIL wr_wait_d got d_ready %b a_valid %b want 1 0", tl_h.d_ready, tl_h.a_valid);
    end
    d_respond(32'h0, 1'b0);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++; $display("FAIL wr_rsp got valid %b data %h want 1 4b", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL wr_done got busy %b tx_valid %b want 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_read();
    logic [7:0] cmd [5] = '{8'h52, 8'h04, 8'h00, 8'h01, 8'h00};
    logic [7:0] rsp [5] = '{8'h4B, 8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    checks++; if (tl_h.a_valid !== 1'b1 || tl_h.a_opcode !== Get) begin
      errors++; $display("FAIL rd_req got valid %b op %h want 1 4", tl_h.a_valid, tl_h.a_opcode);
    end
    checks++; if (tl_h.a_address !== 32'h0001_0004 || tl_h.a_data !== 32'h0 || tl_h.a_mask !== 4'hF) begin
      errors++; $display("FAIL rd_fields got addr %h data %h mask %h want 00010004 0 f", tl_h.a_address, tl_h.a_data, tl_h.a_mask);
    end
    // A D beat in the A-handshake cycle must be ignored
    d_valid = 1'b1;
    d_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    d_valid = 1'b0;
    checks++; if (tx_valid !== 1'b0 || tl_h.d_ready !== 1'b1) begin
      errors++; $display("FAIL rd_early_d got tx_valid %b d_ready %b want 0 1", tx_valid, tl_h.d_ready);
    end
    d_respond(32'h1234_5678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== rsp[i]) begin
        errors++; $display("FAIL rd_tx%0d got valid %b data %h want 1 %h", i, tx_valid, tx_data, rsp[i]);
      end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_done got busy %b want 0", busy); end
  endtask

  task automatic test_error();
    logic [7:0] cmd [5] = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    checks++; if (tl_h.a_valid !== 1'b1 || tl_h.a_address !== 32'h0000_0008) begin
      errors++; $display("FAIL err_req got valid %b addr %h want 1 00000008", tl_h.a_valid, tl_h.a_address);
    end
    @(negedge clk);
    d_respond(32'hFFFF_FFFF, 1'b1);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin
      errors++; $display("FAIL err_rsp got valid %b data %h want 1 45", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL err_done got busy %b tx_valid %b want 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h41);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F || tl_h.a_valid !== 1'b0) begin
        errors++; $display("FAIL unk%0d got valid %b data %h a_valid %b want 1 3f 0", k, tx_valid, tx_data, tl_h.a_valid);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unk%0d_idle got busy %b want 0", k, busy); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] cmd [9] = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    a_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(cmd[i]);
    for (int i = 0; i < 20; i++) begin
      checks++; if (tl_h.a_valid !== 1'b1 || tl_h.a_opcode !== PutFullData ||
                    tl_h.a_address !== 32'h0000_0010 || tl_h.a_data !== 32'h1122_3344) begin
        errors++; $display("FAIL bp_hold%0d got valid %b addr %h data %h want 1 00000010 11223344",
                           i, tl_h.a_valid, tl_h.a_address, tl_h.a_data);
      end
      rx_valid = (i == 5);
      rx_data  = 8'h57;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
    a_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    d_respond(32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
        errors++; $display("FAIL bp_tx_hold%0d got valid %b data %h want 1 4b", i, tx_valid, tx_data);
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL bp_done got busy %b overrun %b want 0 1", busy, overrun);
    end
  endtask

  task automatic test_partial_timeout();
    logic seen_tx = 1'b0;
    send_byte(8'h57);
    send_byte(8'h00);
    for (int i = 0; i < 126; i++) begin
      if (i == 125) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_not_early got busy %b want 1", busy); end
      end
      seen_tx = seen_tx | tx_valid;
      @(negedge clk);
    end
`ifdef UART_BRIDGE_TIMEOUT_EN
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy %b want 0", busy); end
`else
    repeat (100) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_wait got busy %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    checks++; if (seen_tx !== 1'b0) begin errors++; $display("FAIL tmo_no_tx got %b want 0", seen_tx); end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] cmd [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    @(negedge clk);
    checks++; if (tl_h.d_ready !== 1'b1) begin errors++; $display("FAIL mid_wait_d got %b want 1", tl_h.d_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (tl_h.d_ready !== 1'b0 || tl_h.a_valid !== 1'b0 || busy !== 1'b0 ||
                  tx_valid !== 1'b0 || tx_data !== 8'h00 || overrun !== 1'b0) begin
      errors++; $display("FAIL mid_reset got d_ready %b a_valid %b busy %b tx_valid %b tx_data %h overrun %b want 0 0 0 0 00 0",
                         tl_h.d_ready, tl_h.a_valid, busy, tx_valid, tx_data, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h41);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
      errors++; $display("FAIL mid_recover got valid %b data %h want 1 3f", tx_valid, tx_data);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_error();
    test_back_to_back();
    test_backpressure();
    test_partial_timeout();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_tlul_bridge.md
# uart_tlul_bridge

Host-side TL-UL initiator that turns a byte-stream command protocol, typically fed by a UART PHY, into single-word TL-UL Get/PutFullData transactions on a crossbar host port. It lets an external tool load and inspect the management and vicuna scratchpads and the peripherals without a running core. It is the initiator end of the same bus protocol the scratchpads and simple_uart answer as devices. At most one transaction is outstanding.

## Interface
- ClockFrequency, 125_000_000: clock rate in Hz; used only for the timeout.
- TimeoutUs, 1000: inter-byte timeout in microseconds.
- SourceId, 8'h0: constant a_source.
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- rx_valid_i  input  1  one-cycle strobe; a received byte is present.
- rx_data_i  input  8  received byte.
- tx_valid_o  output  1  response byte valid.
- tx_data_o  output  8  response byte.
- tx_ready_i  input  1  PHY accepts the byte this cycle.
- tl_h_o  output  tlul_pkg::tl_h2d_t  A-channel request and d_ready.
- tl_h_i  input  tlul_pkg::tl_d2h_t  D-channel response and a_ready.
- busy_o  output  1  high when the FSM is not in IDLE.
- overrun_o  output  1  sticky; a byte was dropped.

## Operation
- Commands:
  - 'W' (0x57): 4 address bytes, then 4 data bytes, all LSB first.
  - 'R' (0x52): 4 address bytes, LSB first.
- Responses:
  - Write: 'K' (0x4B) on success.
  - Read: 'K' followed by 4 data bytes, LSB first.
  - Error: 'E' (0x45) alone whenever d_error=1.
  - Unknown command byte: '?' (0x3F), then return to IDLE.
- Request encoding:
  - a_address = {addr[31:2], 2'b00}.
  - a_size=2, a_mask=4'hF, a_source=SourceId.
  - a_opcode: PutFullData for 'W', Get for 'R'.
  - a_data = the assembled word for writes, 0 for reads.
  - a_user is generated by tlul_cmd_intg_gen; the D-channel integrity is not checked.
- FSM states: IDLE, ADDR, DATA, REQ, WAIT_D, TX_STAT, TX_DATA.
  - IDLE: 'W' or 'R' goes to ADDR. Any other byte loads '?' and goes to TX_STAT.
  - ADDR: byte counter 0..3. At count 3, 'W' goes to DATA and 'R' goes to REQ.
  - DATA: byte counter 0..3. At count 3, go to REQ.
  - REQ: a_valid=1, all A fields held stable. Leave on a_valid&&a_ready, then go to WAIT_D.
  - WAIT_D: d_ready=1. On d_valid, latch d_data and d_error, then go to TX_STAT.
  - TX_STAT: tx_valid=1, tx_data held stable. On tx_ready:
    - read with no error goes to TX_DATA;
    - otherwise go to IDLE.
  - TX_DATA: sends 4 bytes, counter 0..3. Go to IDLE after the 4th handshake.
- Byte drops:
  - rx_valid_i in REQ, WAIT_D, TX_STAT or TX_DATA drops the byte and sets overrun_o.
  - overrun_o clears only on reset.
- A response with mismatched d_source is still consumed; integrity handling is unchanged.

## Timing
- Reset values: all tl_h_o valid signals 0, d_ready 0, tx_valid_o 0, tx_data_o 0, busy_o 0, overrun_o 0, FSM in IDLE, counters 0.
- Request latency: a_valid rises on the cycle after the last parameter byte's rx_valid_i.
- D phase: d_ready is asserted no earlier than the cycle after the A handshake. A d_valid arriving in the same cycle as the A handshake is not accepted.
- Response latency: tx_valid_o rises on the cycle after the D handshake.
- Back-to-back commands: the first byte of the next command is accepted in IDLE, on the cycle after the last tx handshake.
- Reset mid-transaction drops all state, including a pending a_valid. The bench must not expect the D response to that transaction.
- Counter widths: 2 bits for byte counters. The timeout counter width is $clog2(ClockFrequency/1_000_000*TimeoutUs+1).

## Configuration
- UART_BRIDGE_TIMEOUT_EN defined:
  - The timeout counter runs in ADDR and DATA and is cleared on every rx_valid_i.
  - On reaching the limit the FSM returns to IDLE, discards the partial command, and sends no response.
- UART_BRIDGE_TIMEOUT_EN undefined: no counter is built, and a partial command waits indefinitely.

## Structure
- uart_bridge_pkg holds:
  - command and response byte constants (CmdWrite, CmdRead, RspOk, RspErr, RspUnknown);
  - the FSM state enum.
- Sub-module uart_bridge_tl_req holds the REQ and WAIT_D handshakes and the integrity generation. The parser and response sequencing stay in the top.

## Test plan
- Write: send 57 00 00 01 00 EF BE AD DE, with device a_ready=1 and d_error=0.
  - Expect one PutFullData, address 0x0001_0000, data 0xDEADBEEF, mask F.
  - Then tx byte 4B.
- Read: send 52 04 00 01 00, with the device returning 0x12345678.
  - Expect a Get at address 0x0001_0004.
  - Then tx bytes 4B 78 56 34 12.
- Error: read with d_error=1 -> tx byte 45 only.
- Unknown command: send 41 -> tx byte 3F, no A transaction, busy_o returns to 0.
- Backpressure and overrun:
  - Hold a_ready=0 for 20 cycles and inject an rx byte in REQ -> a_valid and A fields stay stable, overrun_o=1.
  - Hold tx_ready_i=0 -> tx_data_o stays stable.
- Timeout and reset (UART_BRIDGE_TIMEOUT_EN defined, TimeoutUs=1):
  - Send 57 00, then idle for 126 cycles -> FSM returns to IDLE with no tx.
  - Separately, assert rst_ni low in WAIT_D -> all outputs reach their reset values immediately.
